// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmitter and the future receiver.
// The TX_PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_PAR_NONE = 0;
  localparam int UART_PAR_EVEN = 1;
  localparam int UART_PAR_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: ready/valid word input and serial-line status of the UART transmitter.
// The producer side uses the master modport. The transmitter uses the slave modport.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);

  logic                 i_Tx_DV;
  logic [DATA_BITS-1:0] i_Tx_Data;
  logic                 o_Tx_Ready;
  logic                 o_Tx_Active;
  logic                 o_Tx_Serial;
  logic                 o_Tx_Done;

  modport master (
    output i_Tx_DV,
    output i_Tx_Data,
    input  o_Tx_Ready,
    input  o_Tx_Active,
    input  o_Tx_Serial,
    input  o_Tx_Done
  );

  modport slave (
    input  i_Tx_DV,
    input  i_Tx_Data,
    output o_Tx_Ready,
    output o_Tx_Active,
    output o_Tx_Serial,
    output o_Tx_Done
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter. It counts 0..CLKS_PER_BIT-1 while enabled.
// o_Tc flags the last cycle of a bit.
// o_Tc_Next flags that the next cycle will be the last cycle of a bit, so the caller can register outputs that align with it.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_En,
  output logic o_Tc,
  output logic o_Tc_Next
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt_r;

  assign o_Tc      = (cnt_r == CNT_W'(CLKS_PER_BIT - 1));
  assign o_Tc_Next = i_En && (cnt_r == CNT_W'(CLKS_PER_BIT - 2));

  // Free-run within a frame, wrap at terminal count, hold at zero when idle
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset)
      cnt_r <= '0;
    else if (!i_En || o_Tc)
      cnt_r <= '0;
    else
      cnt_r <= cnt_r + 1'b1;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with a ready/valid input and back-to-back frames.
// Optional feature macro: UART_TX_PARITY_EN. When it is defined, the transmitter builds the parity
// stage, and PARITY selects none, even or odd parity. Without the macro, every frame is sent without parity.
// All outputs are registered. Each output is computed from the next-state values, so it changes on the
// same edge as the state it describes.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  uart_tx_frame_if.slave tx
);

  localparam int              IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic            LAST_STOP = 1'(STOP_BITS - 1);
`ifdef UART_TX_PARITY_EN
  localparam bit              PAR_ON    = (PARITY != UART_PAR_NONE);
  localparam logic            PAR_ODD   = (PARITY == UART_PAR_ODD);
`endif

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || PARITY < 0 || PARITY > 2) begin : g_bad_cfg
    $error("uart_tx_frame: illegal parameter set");
  end

  tx_state_t            state_r, state_n;
  logic [DATA_BITS-1:0] shift_r, shift_n;
  logic [IDX_W-1:0]     idx_r, idx_n;
  logic                 stop_r, stop_n;
`ifdef UART_TX_PARITY_EN
  logic                 par_r, par_n;
`endif
  logic                 tc, tc_next, run, accept, last_stop_n;
  logic                 serial_r, serial_n, ready_r, ready_n;
  logic                 active_r, active_n, done_r, done_n;

  assign run    = (state_r != TX_IDLE);
  assign accept = tx.i_Tx_DV && ready_r;

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_En      (run),
    .o_Tc      (tc),
    .o_Tc_Next (tc_next)
  );

  // Next-state, shift register, indices and registered-output next values
  always_comb begin
    state_n = state_r;
    shift_n = shift_r;
    idx_n   = idx_r;
    stop_n  = stop_r;
`ifdef UART_TX_PARITY_EN
    par_n   = par_r;
`endif
    case (state_r)
      TX_IDLE: begin
        if (accept) begin
          state_n = TX_START;
          shift_n = tx.i_Tx_Data;
          idx_n   = '0;
          stop_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_n   = 1'b0;
`endif
        end
      end
      TX_START: begin
        if (tc) state_n = TX_DATA;
      end
      TX_DATA: begin
        if (tc) begin
          shift_n = shift_r >> 1;
`ifdef UART_TX_PARITY_EN
          par_n   = par_r ^ shift_r[0];
`endif
          if (idx_r == LAST_IDX) begin
            idx_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n = PAR_ON ? TX_PARITY : TX_STOP;
`else
            state_n = TX_STOP;
`endif
          end else begin
            idx_n = idx_r + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (tc) state_n = TX_STOP;
      end
`endif
      TX_STOP: begin
        if (tc) begin
          if (stop_r == LAST_STOP) begin
            stop_n = 1'b0;
            if (accept) begin
              state_n = TX_START;
              shift_n = tx.i_Tx_Data;
`ifdef UART_TX_PARITY_EN
              par_n   = 1'b0;
`endif
            end else begin
              state_n = TX_IDLE;
            end
          end else begin
            stop_n = stop_r + 1'b1;
          end
        end
      end
      default: state_n = TX_IDLE;
    endcase

    serial_n = 1'b1;
    case (state_n)
      TX_START:  serial_n = 1'b0;
      TX_DATA:   serial_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: serial_n = par_n ^ PAR_ODD;
`endif
      default:   serial_n = 1'b1;
    endcase

    last_stop_n = (state_n == TX_STOP) && (stop_n == LAST_STOP) && tc_next;
    ready_n     = (state_n == TX_IDLE) || last_stop_n;
    done_n      = last_stop_n;
    active_n    = (state_n != TX_IDLE);
  end

  // Control state and output registers; reset aborts any frame without a Done pulse
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_r  <= TX_IDLE;
      idx_r    <= '0;
      stop_r   <= 1'b0;
      serial_r <= 1'b1;
      ready_r  <= 1'b1;
      active_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      idx_r    <= idx_n;
      stop_r   <= stop_n;
      serial_r <= serial_n;
      ready_r  <= ready_n;
      active_r <= active_n;
      done_r   <= done_n;
    end
  end

  // Payload datapath (no reset: reloaded on every accept)
  always_ff @(posedge i_Clock) begin
    shift_r <= shift_n;
`ifdef UART_TX_PARITY_EN
    par_r   <= par_n;
`endif
  end

  assign tx.o_Tx_Serial = serial_r;
  assign tx.o_Tx_Ready  = ready_r;
  assign tx.o_Tx_Active = active_r;
  assign tx.o_Tx_Done   = done_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame with three instances at CLKS_PER_BIT=4.
// dut0 is 8N1, dut1 is 7 data bits / even parity / 2 stop bits, and dut2 is 8 data bits / odd parity / 1 stop bit.
// Expected line patterns are hand-computed, LSB first: bit 0 is the start bit.
module tb_uart_tx_frame;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_frame_if #(.DATA_BITS(8)) if0 ();
  uart_tx_frame_if #(.DATA_BITS(7)) if1 ();
  uart_tx_frame_if #(.DATA_BITS(8)) if2 ();

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY(0))
    dut0 (.i_Clock(clk), .i_Reset(rst), .tx(if0));
  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .PARITY(1))
    dut1 (.i_Clock(clk), .i_Reset(rst), .tx(if1));
  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY(2))
    dut2 (.i_Clock(clk), .i_Reset(rst), .tx(if2));

  logic       dv [3];
  logic [8:0] tx_word [3];
  logic       ser [3];
  logic       rdy [3];
  logic       act [3];
  logic       done [3];

  assign if0.i_Tx_DV = dv[0];
  assign if1.i_Tx_DV = dv[1];
  assign if2.i_Tx_DV = dv[2];
  assign if0.i_Tx_Data = tx_word[0][7:0];
  assign if1.i_Tx_Data = tx_word[1][6:0];
  assign if2.i_Tx_Data = tx_word[2][7:0];
  assign ser[0] = if0.o_Tx_Serial;  assign ser[1] = if1.o_Tx_Serial;  assign ser[2] = if2.o_Tx_Serial;
  assign rdy[0] = if0.o_Tx_Ready;   assign rdy[1] = if1.o_Tx_Ready;   assign rdy[2] = if2.o_Tx_Ready;
  assign act[0] = if0.o_Tx_Active;  assign act[1] = if1.o_Tx_Active;  assign act[2] = if2.o_Tx_Active;
  assign done[0] = if0.o_Tx_Done;   assign done[1] = if1.o_Tx_Done;   assign done[2] = if2.o_Tx_Done;

  // Hand-computed line images (bit 0 = start bit)
  localparam logic [15:0] EXP_A5 = 16'h034A;  // 0,1,0,1,0,0,1,0,1,1
  localparam logic [15:0] EXP_3C = 16'h0278;  // 0,0,0,1,1,1,1,0,0,1
  localparam logic [15:0] EXP_C3 = 16'h0386;  // 0,1,1,0,0,0,0,1,1,1
`ifdef UART_TX_PARITY_EN
  localparam logic [15:0] EXP_41 = 16'h0682;  // start, 1000001, parity 0, stop, stop
  localparam int          NB_41  = 11;
  localparam logic [15:0] EXP_00 = 16'h0600;  // start, 00000000, parity 1, stop
  localparam int          NB_00  = 11;
`else
  localparam logic [15:0] EXP_41 = 16'h0382;  // start, 1000001, stop, stop
  localparam int          NB_41  = 10;
  localparam logic [15:0] EXP_00 = 16'h0200;  // start, 00000000, stop
  localparam int          NB_00  = 10;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Send one word on instance d and check every cycle of the frame plus the idle cycle after it.
  // When poke_at is nonzero, the task asserts DV with all-ones for 4 cycles mid-frame.
  task automatic run_frame(input int d, input logic [8:0] word, input logic [15:0] bits,
                           input int nbits, input string tag, input int poke_at);
    int n;
    n = nbits * CPB;
    @(negedge clk);
    chk_eq({tag, "_rdy_idle"}, rdy[d], 1);
    dv[d] = 1'b1;
    tx_word[d] = word;
    @(negedge clk);
    dv[d] = 1'b0;
    for (int i = 1; i <= n; i++) begin
      if (i == poke_at) begin
        dv[d] = 1'b1;
        tx_word[d] = 9'h1FF;
      end
      if (poke_at != 0 && i == poke_at + 4) dv[d] = 1'b0;
      chk_eq({tag, "_ser"}, ser[d], bits[(i-1)/CPB]);
      chk_eq({tag, "_act"}, act[d], 1);
      chk_eq({tag, "_done"}, done[d], (i == n));
      chk_eq({tag, "_rdy"}, rdy[d], (i == n));
      @(negedge clk);
    end
    chk_eq({tag, "_idle_ser"}, ser[d], 1);
    chk_eq({tag, "_idle_act"}, act[d], 0);
    chk_eq({tag, "_idle_done"}, done[d], 0);
    chk_eq({tag, "_idle_rdy"}, rdy[d], 1);
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      dv[k] = 1'b0;
      tx_word[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk_eq("rst_ser", ser[0], 1);
    chk_eq("rst_rdy", rdy[0], 1);
    chk_eq("rst_act", act[0], 0);
    chk_eq("rst_done", done[0], 0);
    rst = 1'b0;

    // Single 8N1 frame
    run_frame(0, 9'h0A5, EXP_A5, 10, "a5", 0);

    // Back-to-back: DV held, second word taken on the first frame's Done cycle
    @(negedge clk);
    chk_eq("b2b_rdy_idle", rdy[0], 1);
    dv[0] = 1'b1;
    tx_word[0] = 9'h03C;
    @(negedge clk);
    tx_word[0] = 9'h0C3;
    for (int i = 1; i <= 80; i++) begin
      if (i == 41) dv[0] = 1'b0;
      chk_eq("b2b_ser", ser[0], (i <= 40) ? EXP_3C[(i-1)/CPB] : EXP_C3[(i-41)/CPB]);
      chk_eq("b2b_act", act[0], 1);
      chk_eq("b2b_done", done[0], (i == 40 || i == 80));
      @(negedge clk);
    end
    chk_eq("b2b_idle_ser", ser[0], 1);
    chk_eq("b2b_idle_act", act[0], 0);

    // DV mid-frame is ignored; no extra frame follows
    run_frame(0, 9'h0A5, EXP_A5, 10, "poke", 15);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk_eq("poke_after_ser", ser[0], 1);
      chk_eq("poke_after_act", act[0], 0);
    end

    // Parity / stop-bit variants
    run_frame(1, 9'h041, EXP_41, NB_41, "p7e2", 0);
    run_frame(2, 9'h000, EXP_00, NB_00, "p8o1", 0);

    // Reset during DATA bit 3 (line bit 4, cycles 17..20) of 0xF7
    @(negedge clk);
    dv[0] = 1'b1;
    tx_word[0] = 9'h0F7;
    @(negedge clk);
    dv[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk_eq("rst_pre_ser", ser[0], 0);
    chk_eq("rst_pre_rdy", rdy[0], 0);
    rst = 1'b1;
    #1;
    chk_eq("rst_mid_ser", ser[0], 1);
    chk_eq("rst_mid_rdy", rdy[0], 1);
    chk_eq("rst_mid_act", act[0], 0);
    chk_eq("rst_mid_done", done[0], 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (done[0] || !ser[0]) pulses++;
    end
    chk_eq("rst_quiet", pulses, 0);
    run_frame(0, 9'h0A5, EXP_A5, 10, "post_rst", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
